sdram_arbiter: RTL and testbench

Top-level command scheduler for the SDRAM controller. It holds the command bus in the power-up init sequence until the init sequencer reports completion. It then arbitrates the bus between periodic auto-refresh, write bursts and read bursts, and muxes the selected sub-module's command/address onto the SDRAM pins. It also owns the refresh interval timer.

---
 rtl/sdram_arbiter_if.sv | 57 +++++
 rtl/sdram_arbiter.sv | 158 +++++++++++++++
 tb/tb_sdram_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: bundle between the SDRAM command arbiter and its sub-modules / pins.
//   init sequencer : flag_init_end, init_cmd, init_addr
//   auto-refresh   : aref_en (grant), aref_end, aref_cmd
//   write / read   : *_req, *_en (grant), *_end, *_cmd, *_addr, *_ba
//   SDRAM pins     : sdram_cmd, sdram_addr, sdram_ba
//   status         : ref_overrun
// Modport slave is the arbiter side; master is the sub-module / environment side.
interface sdram_arbiter_if;
    localparam int unsigned CMD_W  = 4;
    localparam int unsigned ADDR_W = 13;
    localparam int unsigned BA_W   = 2;

    logic              flag_init_end;
    logic [CMD_W-1:0]  init_cmd;
    logic [ADDR_W-1:0] init_addr;

    logic              aref_en;
    logic              aref_end;
    logic [CMD_W-1:0]  aref_cmd;

    logic              wr_req;
    logic              wr_en;
    logic              wr_end;
    logic [CMD_W-1:0]  wr_cmd;
    logic [ADDR_W-1:0] wr_addr;
    logic [BA_W-1:0]   wr_ba;

    logic              rd_req;
    logic              rd_en;
    logic              rd_end;
    logic [CMD_W-1:0]  rd_cmd;
    logic [ADDR_W-1:0] rd_addr;
    logic [BA_W-1:0]   rd_ba;

    logic [CMD_W-1:0]  sdram_cmd;
    logic [ADDR_W-1:0] sdram_addr;
    logic [BA_W-1:0]   sdram_ba;
    logic              ref_overrun;

    modport slave (
        input  flag_init_end, init_cmd, init_addr,
        input  aref_end, aref_cmd,
        input  wr_req, wr_end, wr_cmd, wr_addr, wr_ba,
        input  rd_req, rd_end, rd_cmd, rd_addr, rd_ba,
        output aref_en, wr_en, rd_en,
        output sdram_cmd, sdram_addr, sdram_ba, ref_overrun
    );

    modport master (
        output flag_init_end, init_cmd, init_addr,
        output aref_end, aref_cmd,
        output wr_req, wr_end, wr_cmd, wr_addr, wr_ba,
        output rd_req, rd_end, rd_cmd, rd_addr, rd_ba,
        input  aref_en, wr_en, rd_en,
        input  sdram_cmd, sdram_addr, sdram_ba, ref_overrun
    );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: SDRAM command scheduler.
//   Holds the command bus for the init sequencer until flag_init_end, then
//   arbitrates between auto-refresh, write and read bursts, muxes the winner's
//   command/address onto the SDRAM pins and owns the refresh interval timer.
// Ports:
//   sclk   - system clock, rising edge
//   reset  - synchronous, active-high
//   bus    - sdram_arbiter_if.slave (sub-module handshakes, SDRAM pins, ref_overrun)
// Parameters:
//   REF_PERIOD - auto-refresh interval in sclk cycles, legal 16..8191
module sdram_arbiter #(
    parameter int unsigned REF_PERIOD = 390
) (
    input  logic           sclk,
    input  logic           reset,
    sdram_arbiter_if.slave bus
);
    localparam int unsigned CNT_W  = 13;
    localparam int unsigned CMD_W  = 4;
    localparam int unsigned ADDR_W = 13;
    localparam int unsigned BA_W   = 2;

    localparam logic [CMD_W-1:0] CMD_NOP  = 4'b0111;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REF_PERIOD - 1);

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        ARBIT = 3'd1,
        AREF  = 3'd2,
        WRITE = 3'd3,
        READ  = 3'd4
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_ref_cnt;
    logic              r_ref_pend;
    logic              r_last_wr;      // 1: last served was WRITE, 0: READ
    logic              r_ref_overrun;

    state_t            w_state_nxt;
    logic              w_last_wr_nxt;
    logic [CNT_W-1:0]  w_ref_cnt_nxt;
    logic              w_ref_pend_nxt;
    logic              w_ref_overrun_nxt;
    logic              w_cnt_wrap;
    logic              w_aref_enter;

    logic [CMD_W-1:0]  w_cmd;
    logic [ADDR_W-1:0] w_addr;
    logic [BA_W-1:0]   w_ba;

    // State and refresh bookkeeping registers
    always_ff @(posedge sclk) begin
        if (reset) begin
            r_state       <= INIT;
            r_ref_cnt     <= '0;
            r_ref_pend    <= 1'b0;
            r_last_wr     <= 1'b0;
            r_ref_overrun <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ref_cnt     <= w_ref_cnt_nxt;
            r_ref_pend    <= w_ref_pend_nxt;
            r_last_wr     <= w_last_wr_nxt;
            r_ref_overrun <= w_ref_overrun_nxt;
        end
    end

    // Next-state: refresh first, then round-robin between write and read
    always_comb begin
        w_state_nxt   = r_state;
        w_last_wr_nxt = r_last_wr;
        case (r_state)
            INIT: begin
                if (bus.flag_init_end) w_state_nxt = ARBIT;
            end
            ARBIT: begin
                if (r_ref_pend)                    w_state_nxt = AREF;
                else if (bus.wr_req && bus.rd_req) w_state_nxt = r_last_wr ? READ : WRITE;
                else if (bus.wr_req)               w_state_nxt = WRITE;
                else if (bus.rd_req)               w_state_nxt = READ;
            end
            AREF: begin
                if (bus.aref_end) w_state_nxt = ARBIT;
            end
            WRITE: begin
                if (bus.wr_end) begin
                    w_state_nxt   = ARBIT;
                    w_last_wr_nxt = 1'b1;
                end
            end
            READ: begin
                if (bus.rd_end) begin
                    w_state_nxt   = ARBIT;
                    w_last_wr_nxt = 1'b0;
                end
            end
            default: w_state_nxt = INIT;
        endcase
    end

    // Refresh timer: free-running outside INIT; a wrap coinciding with AREF
    // entry keeps the request pending instead of flagging an overrun
    always_comb begin
        w_cnt_wrap        = (r_state != INIT) && (r_ref_cnt == CNT_LAST);
        w_aref_enter      = (r_state == ARBIT) && r_ref_pend;
        w_ref_cnt_nxt     = r_ref_cnt;
        w_ref_pend_nxt    = r_ref_pend;
        w_ref_overrun_nxt = r_ref_overrun;

        if (r_state == INIT)  w_ref_cnt_nxt = '0;
        else if (w_cnt_wrap)  w_ref_cnt_nxt = '0;
        else                  w_ref_cnt_nxt = r_ref_cnt + CNT_W'(1);

        if (w_cnt_wrap)        w_ref_pend_nxt = 1'b1;
        else if (w_aref_enter) w_ref_pend_nxt = 1'b0;

        if (w_cnt_wrap && r_ref_pend && !w_aref_enter) w_ref_overrun_nxt = 1'b1;
    end

    // Pin mux, decoded from the state register only
    always_comb begin
        w_cmd  = CMD_NOP;
        w_addr = '0;
        w_ba   = '0;
        case (r_state)
            INIT: begin
                w_cmd  = bus.init_cmd;
                w_addr = bus.init_addr;
            end
            AREF: begin
                w_cmd  = bus.aref_cmd;
            end
            WRITE: begin
                w_cmd  = bus.wr_cmd;
                w_addr = bus.wr_addr;
                w_ba   = bus.wr_ba;
            end
            READ: begin
                w_cmd  = bus.rd_cmd;
                w_addr = bus.rd_addr;
                w_ba   = bus.rd_ba;
            end
            default: begin
                w_cmd  = CMD_NOP;
            end
        endcase
    end

    assign bus.aref_en     = (r_state == AREF);
    assign bus.wr_en       = (r_state == WRITE);
    assign bus.rd_en       = (r_state == READ);
    assign bus.sdram_cmd   = w_cmd;
    assign bus.sdram_addr  = w_addr;
    assign bus.sdram_ba    = w_ba;
    assign bus.ref_overrun = r_ref_overrun;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed bench for sdram_arbiter with REF_PERIOD=16.
// Grant timelines are hand-written strings, one char per sclk edge after init exit:
//   N = no grant, W = wr_en, R = rd_en, A = aref_en.
module tb_sdram_arbiter;
    localparam int unsigned REF_P = 16;

    logic sclk;
    logic reset;
    int   n_checks;
    int   n_pass;

    sdram_arbiter_if bus ();

    sdram_arbiter #(.REF_PERIOD(REF_P)) u_dut (
        .sclk  (sclk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    function automatic string rep(input string c, input int n);
        string s;
        s = "";
        for (int i = 0; i < n; i++) s = {s, c};
        return s;
    endfunction

    task automatic check_grants(input string tag, input byte c);
        logic [2:0] e;
        case (c)
            "A":     e = 3'b100;
            "W":     e = 3'b010;
            "R":     e = 3'b001;
            default: e = 3'b000;
        endcase
        check(tag, 32'({bus.aref_en, bus.wr_en, bus.rd_en}), 32'(e));
    endtask

    task automatic check_pins(input string tag, input logic [3:0] cmd,
                              input logic [12:0] addr, input logic [1:0] ba);
        check(tag, 32'({bus.sdram_cmd, bus.sdram_addr, bus.sdram_ba}), 32'({cmd, addr, ba}));
    endtask

    task automatic apply_reset();
        reset             = 1'b1;
        bus.flag_init_end = 1'b0;
        bus.wr_req        = 1'b0;
        bus.rd_req        = 1'b0;
        bus.wr_end        = 1'b0;
        bus.rd_end        = 1'b0;
        bus.aref_end      = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic init_exit();
        bus.flag_init_end = 1'b1;
        tick();
    endtask

    // Walk a grant timeline; the matching *_end is pulsed on the last cycle of each run.
    task automatic run_seq(input string tag, input string seq, input string ovr);
        for (int k = 1; k <= seq.len(); k++) begin
            tick();
            check_grants($sformatf("%s_k%0d", tag, k), seq[k-1]);
            if (k <= ovr.len() && ovr[k-1] != "-")
                check($sformatf("%s_ovr_k%0d", tag, k), 32'(bus.ref_overrun),
                      32'(ovr[k-1] == "1"));
            bus.wr_end   = 1'b0;
            bus.rd_end   = 1'b0;
            bus.aref_end = 1'b0;
            if (k < seq.len() && seq[k] != seq[k-1]) begin
                case (seq[k-1])
                    "W": bus.wr_end   = 1'b1;
                    "R": bus.rd_end   = 1'b1;
                    "A": bus.aref_end = 1'b1;
                    default: ;
                endcase
            end
        end
        bus.wr_end   = 1'b0;
        bus.rd_end   = 1'b0;
        bus.aref_end = 1'b0;
    endtask

    initial begin
        int hi;
        n_checks      = 0;
        n_pass        = 0;
        reset         = 1'b1;
        bus.init_cmd  = 4'b0010;
        bus.init_addr = 13'h0400;
        bus.aref_cmd  = 4'b0001;
        bus.wr_cmd    = 4'b0100;
        bus.wr_addr   = 13'h0ABC;
        bus.wr_ba     = 2'b10;
        bus.rd_cmd    = 4'b0101;
        bus.rd_addr   = 13'h1234;
        bus.rd_ba     = 2'b01;

        // Reset state and init pass-through
        apply_reset();
        check_grants("rst_grants", "N");
        check("rst_ovr", 32'(bus.ref_overrun), 32'd0);
        check_pins("rst_pins", 4'b0010, 13'h0400, 2'b00);
        for (int i = 0; i < 20; i++) begin
            bus.init_cmd  = 4'(i);
            bus.init_addr = 13'(i * 37);
            tick();
            check_pins($sformatf("init_mirror_%0d", i), 4'(i), 13'(i * 37), 2'b00);
            check_grants($sformatf("init_nogrant_%0d", i), "N");
        end
        bus.init_cmd  = 4'b0010;
        bus.init_addr = 13'h0400;
        init_exit();
        check_pins("arbit_nop", 4'b0111, 13'h0000, 2'b00);
        check_grants("arbit_nogrant", "N");
        run_seq("idle", "NNNNN", "");

        // Single write, 8 cycles
        apply_reset();
        init_exit();
        bus.wr_req = 1'b1;
        tick();
        hi = 0;
        for (int k = 1; k <= 8; k++) begin
            if (bus.wr_en) hi++;
            check_pins($sformatf("wr_pins_k%0d", k), 4'b0100, 13'h0ABC, 2'b10);
            if (k == 1) bus.wr_req = 1'b0;
            bus.rd_end = (k == 3);
            if (k == 4) check_grants("wr_ignore_rd_end", "W");
            if (k == 8) bus.wr_end = 1'b1;
            tick();
        end
        bus.wr_end = 1'b0;
        bus.rd_end = 1'b0;
        check("wr_len", 32'(hi), 32'd8);
        check_grants("wr_done", "N");
        check_pins("wr_done_pins", 4'b0111, 13'h0000, 2'b00);
        tick();
        check_grants("wr_idle", "N");

        // Alternating write/read with one NOP between
        apply_reset();
        init_exit();
        bus.wr_req = 1'b1;
        bus.rd_req = 1'b1;
        run_seq("alt", "WWWWNRRRRNWWWWNR", "");

        // Long write: second wrap before service sets overrun
        apply_reset();
        init_exit();
        bus.wr_req = 1'b1;
        bus.rd_req = 1'b1;
        run_seq("ovr", {rep("W", 31), "N", "AAA", "N", "R"},
                {rep("-", 30), "01", rep("-", 4), "1"});

        // Wrap coincides with AREF entry: request stays pending, no overrun
        apply_reset();
        check("ovr_cleared", 32'(bus.ref_overrun), 32'd0);
        init_exit();
        bus.wr_req = 1'b1;
        run_seq("coinc", {rep("W", 30), "N", "AAA", "N", "A"}, {rep("-", 35), "0"});
        check_pins("aref_pins", 4'b0001, 13'h0000, 2'b00);

        // Idle bus: refresh every REF_P cycles
        apply_reset();
        init_exit();
        run_seq("iref", {rep("N", 16), "AAA", rep("N", 13), "AAA", rep("N", 13), "AAA", rep("N", 5)},
                {rep("-", 55), "0"});

        // Reset mid-read discards the pending refresh
        apply_reset();
        init_exit();
        bus.rd_req = 1'b1;
        run_seq("rd", rep("R", 20), "");
        check_pins("rd_pins", 4'b0101, 13'h1234, 2'b01);
        reset             = 1'b1;
        bus.rd_req        = 1'b0;
        bus.flag_init_end = 1'b0;
        tick();
        check_grants("rst_mid_rd", "N");
        check_pins("rst_mid_pins", 4'b0010, 13'h0400, 2'b00);
        reset = 1'b0;
        tick();
        check_grants("reinit_hold", "N");
        init_exit();
        run_seq("reinit", {rep("N", 16), "A"}, "");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
